// File: rtl/jtkcpu_mul.sv
// Iterative shift-add multiplier, 8x8->16 or 16x16->32, signed or unsigned.
// Retires STEP multiplier bits per enabled cycle, then one sign-fix cycle.
module jtkcpu_mul #(
  parameter int unsigned STEP = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cen,
  input  logic [15:0] op0,
  input  logic [15:0] op1,
  input  logic        len,
  input  logic        sign,
  input  logic        start,
  output logic [15:0] prod_lo,
  output logic [15:0] prod_hi,
  output logic        busy,
  output logic        done,
  output logic        c
);

  localparam logic [3:0] Last16 = 4'(16 / STEP - 1);
  localparam logic [3:0] Last8  = 4'(8 / STEP - 1);

  typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

  state_e      state_q, state_d;
  logic [31:0] mcand_q, mcand_d;
  logic [15:0] mplier_q, mplier_d;
  // A 32-bit accumulator cannot overflow: |product| <= 2^30 signed, < 2^32 unsigned.
  logic [31:0] acc_q, acc_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        neg_q, neg_d;
  logic        len_q, len_d;
  logic        sign_q, sign_d;
  logic        done_q, done_d;
  logic [15:0] lo_q, lo_d;
  logic [15:0] hi_q, hi_d;
  logic        c_q, c_d;

  logic [15:0] mag0, mag1;
  logic        msb0, msb1;
  logic [31:0] addend;
  logic [31:0] fixed;

  // Operand magnitudes; 0x8000 (0x80) maps onto itself as an unsigned value.
  always_comb begin
    msb0 = len ? op0[15] : op0[7];
    msb1 = len ? op1[15] : op1[7];
    if (len) begin
      mag0 = (sign && msb0) ? (~op0 + 16'd1) : op0;
      mag1 = (sign && msb1) ? (~op1 + 16'd1) : op1;
    end else begin
      mag0 = {8'h00, (sign && msb0) ? (~op0[7:0] + 8'd1) : op0[7:0]};
      mag1 = {8'h00, (sign && msb1) ? (~op1[7:0] + 8'd1) : op1[7:0]};
    end
  end

  always_comb begin
    addend = '0;
    for (int unsigned i = 0; i < STEP; i++) begin
      if (mplier_q[i]) addend = addend + (mcand_q << i);
    end
    fixed = neg_q ? (~acc_q + 32'd1) : acc_q;
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    len_d    = len_q;
    sign_d   = sign_q;
    done_d   = 1'b0;
    lo_d     = lo_q;
    hi_d     = hi_q;
    c_d      = c_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          mcand_d  = {16'h0000, mag0};
          mplier_d = mag1;
          acc_d    = '0;
          cnt_d    = len ? Last16 : Last8;
          neg_d    = sign & (msb0 ^ msb1);
          len_d    = len;
          sign_d   = sign;
          state_d  = StRun;
        end
      end
      StRun: begin
        acc_d    = acc_q + addend;
        mcand_d  = mcand_q << STEP;
        mplier_d = mplier_q >> STEP;
        cnt_d    = cnt_q - 4'd1;
        if (cnt_q == 4'd0) state_d = StFix;
      end
      StFix: begin
        lo_d    = fixed[15:0];
        if (len_q)       hi_d = fixed[31:16];
        else if (sign_q) hi_d = {16{fixed[15]}};
        else             hi_d = 16'h0000;
        c_d     = len_q ? hi_d[15] : lo_d[7];
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      len_q    <= 1'b0;
      sign_q   <= 1'b0;
      done_q   <= 1'b0;
      lo_q     <= '0;
      hi_q     <= '0;
      c_q      <= 1'b0;
    end else if (cen) begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      len_q    <= len_d;
      sign_q   <= sign_d;
      done_q   <= done_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      c_q      <= c_d;
    end
  end

  assign busy    = (state_q != StIdle);
  assign done    = done_q;
  assign prod_lo = lo_q;
  assign prod_hi = hi_q;
  assign c       = c_q;

endmodule

// File: tb/tb_jtkcpu_mul.sv
// Directed bench for jtkcpu_mul: STEP=1 and STEP=2 instances share one stimulus.
module tb_jtkcpu_mul;

  logic        clk = 1'b0;
  logic        rst, cen, len, sign, start;
  logic [15:0] op0, op1;
  logic [15:0] lo1, hi1, lo2, hi2;
  logic        busy1, done1, c1, busy2, done2, c2;

  int n_tests = 0;
  int n_fail  = 0;

  jtkcpu_mul #(.STEP(1)) u_mul1 (
    .clk(clk), .rst(rst), .cen(cen), .op0(op0), .op1(op1), .len(len), .sign(sign),
    .start(start), .prod_lo(lo1), .prod_hi(hi1), .busy(busy1), .done(done1), .c(c1)
  );

  jtkcpu_mul #(.STEP(2)) u_mul2 (
    .clk(clk), .rst(rst), .cen(cen), .op0(op0), .op1(op1), .len(len), .sign(sign),
    .start(start), .prod_lo(lo2), .prod_hi(hi2), .busy(busy2), .done(done2), .c(c2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full-speed op: count busy/done samples on both instances, then check results.
  task automatic run_op(input string tag, input logic l, input logic s,
                        input logic [15:0] a, input logic [15:0] b,
                        input logic [31:0] exp_p, input logic exp_c);
    int b1 = 0, b2 = 0, d1 = 0, d2 = 0;
    op0 = a; op1 = b; len = l; sign = s; start = 1'b1; cen = 1'b1;
    tick();
    start = 1'b0;
    op0 = 16'($urandom);
    op1 = 16'($urandom);
    for (int i = 0; i < 24; i++) begin
      b1 += int'(busy1); b2 += int'(busy2);
      d1 += int'(done1); d2 += int'(done2);
      tick();
    end
    check({tag, " busy1"}, b1, l ? 17 : 9);
    check({tag, " busy2"}, b2, l ? 9 : 5);
    check({tag, " done1"}, d1, 1);
    check({tag, " done2"}, d2, 1);
    check({tag, " prod1"}, {hi1, lo1}, exp_p);
    check({tag, " prod2"}, {hi2, lo2}, exp_p);
    check({tag, " c1"}, 32'(c1), 32'(exp_c));
    check({tag, " c2"}, 32'(c2), 32'(exp_c));
  endtask

  initial begin
    int b1, b2, d1, d2;
    rst = 1'b1; cen = 1'b0; len = 1'b0; sign = 1'b0; start = 1'b0;
    op0 = 16'h0; op1 = 16'h0;
    tick();
    tick();
    check("rst busy", {30'd0, busy2, busy1}, 32'd0);
    check("rst done", {30'd0, done2, done1}, 32'd0);
    check("rst prod", {hi1, lo1}, 32'h0);
    check("rst c", {30'd0, c2, c1}, 32'd0);
    rst = 1'b0;
    tick();

    run_op("u8 ff*ff",     1'b0, 1'b0, 16'h00FF, 16'h00FF, 32'h0000_FE01, 1'b0);
    run_op("u16 ffff^2",   1'b1, 1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 1'b1);
    run_op("s16 8000^2",   1'b1, 1'b1, 16'h8000, 16'h8000, 32'h4000_0000, 1'b0);
    run_op("s16 -1*3",     1'b1, 1'b1, 16'hFFFF, 16'h0003, 32'hFFFF_FFFD, 1'b1);
    run_op("s8 80*1",      1'b0, 1'b1, 16'h0080, 16'h0001, 32'hFFFF_FF80, 1'b1);
    run_op("s8 -3*5",      1'b0, 1'b1, 16'h00FD, 16'h0005, 32'hFFFF_FFF1, 1'b1);
    run_op("u16 1234*10",  1'b1, 1'b0, 16'h1234, 16'h0010, 32'h0001_2340, 1'b0);
    run_op("u8 hi junk",   1'b0, 1'b0, 16'hAB03, 16'hCD05, 32'h0000_000F, 1'b0);
    run_op("s16 7fff*8000", 1'b1, 1'b1, 16'h7FFF, 16'h8000, 32'hC000_8000, 1'b1);

    // cen alternating 1/0 from the start edge; a start mid-RUN must be ignored.
    b1 = 0; b2 = 0; d1 = 0; d2 = 0;
    op0 = 16'h1234; op1 = 16'h0010; len = 1'b1; sign = 1'b0; start = 1'b1; cen = 1'b1;
    for (int k = 0; k < 40; k++) begin
      tick();
      b1 += int'(busy1); b2 += int'(busy2);
      d1 += int'(done1); d2 += int'(done2);
      if (k == 4) check("cen hold prod", {hi1, lo1}, 32'hC000_8000);
      cen   = ((k + 1) % 2 == 0);
      start = (k + 1 == 10);
      if (k + 1 == 10) begin
        op0 = 16'hFFFF; op1 = 16'hFFFF; sign = 1'b1; len = 1'b0;
      end
    end
    cen = 1'b1;
    check("cen busy1", b1, 34);
    check("cen busy2", b2, 18);
    check("cen done1", d1, 2);
    check("cen done2", d2, 2);
    check("cen prod1", {hi1, lo1}, 32'h0001_2340);
    check("cen prod2", {hi2, lo2}, 32'h0001_2340);

    // Reset on the 5th RUN cycle aborts without a done pulse.
    op0 = 16'hFFFF; op1 = 16'hFFFF; len = 1'b1; sign = 1'b0; start = 1'b1; cen = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    rst = 1'b1;
    tick();
    check("abort busy", {30'd0, busy2, busy1}, 32'd0);
    check("abort prod", {hi1, lo1}, 32'h0);
    check("abort c", 32'(c1), 32'd0);
    rst = 1'b0;
    tick();
    check("abort no done", {30'd0, done2, done1}, 32'd0);
    run_op("rst fresh", 1'b0, 1'b0, 16'h0003, 16'h0005, 32'h0000_000F, 1'b0);

    // start held high: the edge that leaves FIX ignores it, the next accepts it.
    op0 = 16'h0007; op1 = 16'h0009; len = 1'b0; sign = 1'b0; start = 1'b1; cen = 1'b1;
    for (int k = 0; k < 9; k++) tick();
    check("fix busy", 32'(busy1), 32'd1);
    tick();
    check("fix exit busy", 32'(busy1), 32'd0);
    check("fix exit done", 32'(done1), 32'd1);
    tick();
    check("restart busy", 32'(busy1), 32'd1);
    start = 1'b0;
    for (int k = 0; k < 24; k++) tick();
    check("restart prod", {hi1, lo1}, 32'h0000_003F);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/jtkcpu_mul.md
JTKCPU_MUL -- requirements
Module: jtkcpu_mul

Interface
REQ-001 SHALL have parameter STEP, default 1, meaning product bits retired per enabled cycle; legal values 1 or 2.
REQ-002 SHALL have port clk  input  1  system clock; all state changes on posedge clk.
REQ-003 SHALL have port rst  input  1  reset; one clock; reset is synchronous and active-high.
REQ-004 SHALL have port cen  input  1  clock enable; state advances only on posedge clk with cen=1.
REQ-005 SHALL have port op0  input  16  multiplicand; 8-bit mode uses op0[7:0].
REQ-006 SHALL have port op1  input  16  multiplier; 8-bit mode uses op1[7:0].
REQ-007 SHALL have port len  input  1  1=16x16->32, 0=8x8->16.
REQ-008 SHALL have port sign  input  1  1=two's-complement operands, 0=unsigned.
REQ-009 SHALL have port start  input  1  request; sampled with cen=1 and busy=0.
REQ-010 SHALL have port prod_lo  output  16  product bits [15:0].
REQ-011 SHALL have port prod_hi  output  16  product bits [31:16].
REQ-012 SHALL have port busy  output  1  operation in progress.
REQ-013 SHALL have port done  output  1  one-enabled-cycle pulse on completion.
REQ-014 SHALL have port c  output  1  carry flag: len ? prod_hi[15] : prod_lo[7].

Function
REQ-015 SHALL implement states IDLE, RUN, FIX.
REQ-016 IDLE: start=1 and cen=1 SHALL latch op0, op1, len, sign; convert signed operands to magnitudes; record result sign = msb0 XOR msb1 (sign=1 only); clear accumulator; busy=1 next cycle; go to RUN.
REQ-017 RUN: SHALL do shift-add of STEP multiplier bits per enabled cycle; N = (len?16:8)/STEP enabled cycles, then go to FIX.
REQ-018 FIX: SHALL negate the full-width accumulator if result sign set, else pass it through; on exit load prod_hi/prod_lo, assert done, clear busy, go to IDLE.
REQ-019 FIX SHALL always take exactly one enabled cycle, including unsigned ops, so busy lasts exactly N+1 enabled cycles.
REQ-020 8-bit mode: prod_lo SHALL hold the 16-bit product; prod_hi SHALL be 0 when unsigned, or sign extension of prod_lo[15] when signed.
REQ-021 Signed magnitude of 0x8000 (0x80 in 8-bit) SHALL be 0x8000 (0x80) with no overflow; accumulator is 32 bits (16 in 8-bit mode) plus a carry bit.
REQ-022 start while busy=1 SHALL be ignored, with no effect on the running op or latched operands.
REQ-023 Operand inputs SHALL be don't-care after the start cycle.
REQ-024 cen=0 SHALL freeze all state and outputs; done SHALL stay high until the next enabled cycle, then drop.
REQ-025 prod_hi, prod_lo and c SHALL hold the last result until the next completion; they are not updated during RUN.
REQ-026 start in the same enabled cycle that FIX completes SHALL be ignored, because busy is still 1; it is accepted on the next enabled IDLE cycle.

Reset
REQ-027 rst=1 SHALL, regardless of cen, force IDLE and set busy=0, done=0, prod_hi=0, prod_lo=0, c=0, with the accumulator and latched operands cleared.
REQ-028 rst asserted mid-RUN or mid-FIX SHALL abort the operation with no done pulse; the next start after rst deasserts runs normally.

Verification
REQ-029 len=0, sign=0, op0=0x00FF, op1=0x00FF, STEP=1 -> busy for 9 enabled cycles; prod_lo=0xFE01, prod_hi=0x0000, c=0, one done pulse.
REQ-030 len=1, sign=0, op0=0xFFFF, op1=0xFFFF -> busy for 17 enabled cycles; prod_hi=0xFFFE, prod_lo=0x0001, c=1.
REQ-031 len=1, sign=1, op0=0x8000, op1=0x8000 -> 0x40000000, c=0; op0=0xFFFF, op1=0x0003 -> 0xFFFFFFFD, c=1.
REQ-032 len=0, sign=1, op0=0x0080, op1=0x0001 -> prod_lo=0xFF80, prod_hi=0xFFFF, c=1; repeat with STEP=2 -> busy for 5 enabled cycles, same result.
REQ-033 cen toggled 1/0 alternately during a 16-bit op -> busy spans 34 clocks; result identical to cen=1 run; start pulsed mid-RUN with new operands -> ignored.
REQ-034 rst pulsed on the 5th RUN cycle -> busy=0, prod=0, no done next cycle; a fresh 0x0003*0x0005 -> prod_lo=0x000F.
